// File: rtl/if_stage.sv
// Instruction fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
// Optional macro IF_DELAY_SLOT_EN: keep the delay-slot instruction instead of squashing on redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   StallF,
  input  logic                   StallD,
  input  logic                   PCSrcD,
  input  logic [31:0]            PCBranchD,
  input  logic                   JumpD,
  input  logic [31:0]            JumpTargetD,
  output logic [IMEM_ADDR_W-1:0] ImemAddr,
  input  logic [31:0]            ImemRdata,
  output logic [31:0]            PCF,
  output logic [31:0]            InstrD,
  output logic [31:0]            PCPlus4D,
  output logic                   ValidD,
  output logic [31:0]            FetchCnt
);

  logic [31:0] pcPlus4F;
  logic [31:0] nextPc;
  logic        redirect;
  logic        loadD;
  logic        squashD;

  // Branch/jump in a stalled decode stage is not resolved yet, so it cannot redirect.
  always_comb begin
    pcPlus4F = PCF + 32'd4;
    redirect = (JumpD | PCSrcD) & ~StallD;
    nextPc   = JumpD ? JumpTargetD : (PCSrcD ? PCBranchD : pcPlus4F);
    nextPc   = {nextPc[31:2], 2'b00};
    loadD    = ~StallD;
`ifdef IF_DELAY_SLOT_EN
    squashD  = 1'b0;
`else
    squashD  = redirect;
`endif
  end

  assign ImemAddr = PCF[IMEM_ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      PCF      <= RESET_PC;
      InstrD   <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
      FetchCnt <= 32'd0;
    end else begin
      if (!StallF) begin
        PCF <= redirect ? nextPc : pcPlus4F;
      end
      if (loadD) begin
        if (squashD) begin
          InstrD   <= 32'd0;
          PCPlus4D <= 32'd0;
          ValidD   <= 1'b0;
        end else begin
          InstrD   <= ImemRdata;
          PCPlus4D <= pcPlus4F;
          ValidD   <= 1'b1;
          FetchCnt <= FetchCnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; imem[i] = i + 100.
module tb_if_stage;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, PCSrcD, JumpD;
  logic [31:0] PCBranchD, JumpTargetD;
  logic [7:0]  ImemAddr;
  logic [31:0] ImemRdata;
  logic [31:0] PCF, InstrD, PCPlus4D, FetchCnt;
  logic        ValidD;
  logic [31:0] imem [256];

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(32'h0), .IMEM_ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .JumpTargetD(JumpTargetD),
    .ImemAddr(ImemAddr), .ImemRdata(ImemRdata), .PCF(PCF), .InstrD(InstrD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchCnt(FetchCnt)
  );

  always #5 clk = ~clk;
  assign ImemRdata = imem[ImemAddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then compare every decode-side output and the PC.
  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] p4, input logic v, input logic [31:0] fc);
    @(posedge clk);
    #1;
    check({tag, ".PCF"}, PCF, pc);
    check({tag, ".InstrD"}, InstrD, instr);
    check({tag, ".PCPlus4D"}, PCPlus4D, p4);
    check({tag, ".ValidD"}, 32'(ValidD), 32'(v));
    check({tag, ".FetchCnt"}, FetchCnt, fc);
  endtask

  task automatic idle();
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    PCBranchD = 32'h0; JumpTargetD = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'(i + 100);
    idle();
    rst = 1'b1;
    step("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++)
      step("seq", 32'(4 * k), 32'(100 + k - 1), 32'(4 * k), 1'b1, 32'(k));

    rst = 1'b1;
    step("reset2", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0;
    step("pre0", 32'd4, 32'd100, 32'd4, 1'b1, 32'd1);
    step("pre1", 32'd8, 32'd101, 32'd8, 1'b1, 32'd2);
    StallF = 1'b1; StallD = 1'b1;
    for (int k = 0; k < 3; k++) step("stall", 32'd8, 32'd101, 32'd8, 1'b1, 32'd2);
    idle();
    step("resume", 32'd12, 32'd102, 32'd12, 1'b1, 32'd3);
    step("to10", 32'h10, 32'd103, 32'h10, 1'b1, 32'd4);

    PCSrcD = 1'b1; PCBranchD = 32'h40;
    step("branch", 32'h40, DS ? 32'd104 : 32'd0, DS ? 32'h14 : 32'd0, DS, DS ? 32'd5 : 32'd4);
    check("imemaddr", 32'(ImemAddr), 32'h10);
    idle();
    step("postbr", 32'h44, 32'd116, 32'h44, 1'b1, DS ? 32'd6 : 32'd5);

    JumpD = 1'b1; JumpTargetD = 32'h83; PCSrcD = 1'b1; PCBranchD = 32'h40;
    step("jmppri", 32'h80, DS ? 32'd117 : 32'd0, DS ? 32'h48 : 32'd0, DS, DS ? 32'd7 : 32'd5);
    StallD = 1'b1;
    step("jmpstD", 32'h84, DS ? 32'd117 : 32'd0, DS ? 32'h48 : 32'd0, DS, DS ? 32'd7 : 32'd5);
    StallF = 1'b1;
    step("jmpstFD", 32'h84, DS ? 32'd117 : 32'd0, DS ? 32'h48 : 32'd0, DS, DS ? 32'd7 : 32'd5);

    idle();
    PCSrcD = 1'b1; PCBranchD = 32'h20;
    step("br20", 32'h20, DS ? 32'd133 : 32'd0, DS ? 32'h88 : 32'd0, DS, DS ? 32'd8 : 32'd5);
    idle();
    StallD = 1'b1;
    step("drain", 32'h24, DS ? 32'd133 : 32'd0, DS ? 32'h88 : 32'd0, DS, DS ? 32'd8 : 32'd5);
    idle();
    step("drained", 32'h28, 32'd109, 32'h28, 1'b1, DS ? 32'd9 : 32'd6);

    PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFF;
    step("brtop", 32'hFFFF_FFFC, DS ? 32'd110 : 32'd0, DS ? 32'h2C : 32'd0, DS, DS ? 32'd10 : 32'd6);
    check("imemtop", 32'(ImemAddr), 32'hFF);
    idle();
    step("wrap", 32'h0, 32'd355, 32'h0, 1'b1, DS ? 32'd11 : 32'd7);
    step("wrap1", 32'h4, 32'd100, 32'h4, 1'b1, DS ? 32'd12 : 32'd8);

    rst = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h40; StallF = 1'b1;
    step("midrst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0;
    idle();
    step("afterrst", 32'h4, 32'd100, 32'h4, 1'b1, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline CPU.
- Holds the PC, drives the instruction-memory address and computes PC+4.
- Selects the next PC from sequential, branch (PCSrcD/PCBranchD) or jump (JumpD/JumpTargetD) targets.
- Latches InstrD/PCPlus4D into decode, honouring StallF/StallD from the hazard unit and squashing the wrong-path instruction on a taken redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_ADDR_W, 8, word-address width of the instruction memory

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
StallF  input  1  hold PC (from hazard unit)
StallD  input  1  hold IF/ID register (from hazard unit)
PCSrcD  input  1  branch taken, resolved in decode
PCBranchD  input  32  branch target
JumpD  input  1  jump in decode
JumpTargetD  input  32  jump target
ImemAddr  output  IMEM_ADDR_W  word address to instruction memory (combinational read)
ImemRdata  input  32  instruction at ImemAddr, same cycle
PCF  output  32  current fetch PC
InstrD  output  32  instruction in decode
PCPlus4D  output  32  PC+4 of instruction in decode
ValidD  output  1  InstrD is a real fetched instruction
FetchCnt  output  32  number of accepted fetches since reset

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. rst has priority over all other inputs.
- Values on rst: PCF=RESET_PC, InstrD=0 (NOP), PCPlus4D=0, ValidD=0, FetchCnt=0.
- Reset mid-operation discards any pending redirect or stall; the first fetch after rst deasserts is from RESET_PC.
- PCPlus4F = PCF + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- ImemAddr = PCF[IMEM_ADDR_W+1:2]. Instruction-memory latency is 0 cycles, so fetch-to-decode latency is 1 cycle.
- redirect = (JumpD | PCSrcD) & ~StallD. A branch or jump sitting in a stalled decode stage is not yet resolved and is ignored.
- Next-PC priority: JumpD > PCSrcD > sequential. NextPC = JumpD ? JumpTargetD : PCSrcD ? PCBranchD : PCPlus4F, with bits [1:0] forced to 0.
- PC update each edge:
  - StallF=1: PCF holds, even if redirect=1.
  - StallF=0 and redirect=1: PCF <= NextPC.
  - Otherwise: PCF <= PCPlus4F.
- IF/ID update each edge:
  - StallD=1: InstrD, PCPlus4D and ValidD hold.
  - Else, redirect=1 (without DELAY_SLOT_EN): InstrD <= 0, PCPlus4D <= 0, ValidD <= 0 (squash).
  - Else: InstrD <= ImemRdata, PCPlus4D <= PCPlus4F, ValidD <= 1.
- StallF=0 with StallD=1 is legal: PC advances and the fetched word is dropped. The hazard unit relies on this in its drain sequence.
- FetchCnt increments by 1 on every edge where the IF/ID register loads a non-squashed instruction. It wraps 2^32-1 -> 0.
- No combinational path from StallF/StallD to ImemAddr. ImemAddr depends on PCF only.

Optional Feature:
- Macro: IF_DELAY_SLOT_EN.
- Defined: MIPS branch-delay-slot semantics. On redirect the IF/ID register loads ImemRdata normally (ValidD=1, FetchCnt increments); no squash.
- Undefined: squash on redirect as described above; one bubble per taken branch or jump.

Test Plan:
- Reset then run 4 cycles with no stalls, imem[i]=i+100 -> PCF 0,4,8,12,16; InstrD 100,101,102,103 one cycle behind PCF; ValidD=1 from 2nd cycle; FetchCnt=4.
- StallF=StallD=1 for 3 cycles at PCF=8 -> PCF, InstrD and FetchCnt frozen; sequence resumes at PCF=12 after release.
- PCSrcD=1, PCBranchD=32'h40 at PCF=0x10 -> next PCF=0x40. IF_DELAY_SLOT_EN undefined: InstrD=0, ValidD=0 for one cycle. Defined: InstrD=imem[4], ValidD=1.
- JumpD=1 (target 0x80) and PCSrcD=1 (target 0x40) together -> PCF=0x80. Same with StallD=1 -> redirect ignored and PCF follows StallF.
- StallF=0, StallD=1 for one cycle at PCF=0x20 -> PCF=0x24, InstrD held, instruction at 0x20 never reaches decode, FetchCnt unchanged.
- rst asserted for one cycle mid-stream with PCSrcD=1 -> PCF=RESET_PC, InstrD=0, ValidD=0, FetchCnt=0; normal fetch resumes next cycle.
